// File: rtl/padlock_word_ctrl.sv
// padlock_word_ctrl
//   Sequencer and word assembler for the padlock RNG core. It holds the core
//   in reset while idle and synchronises the core's rnd_bit/done signals. It
//   also runs a repetition-count health test on every raw bit, packs accepted
//   bits into WIDTH-bit words and offers each word over a valid/ready
//   handshake.
//
// Parameters
//   WIDTH       output word width (>=2)
//   REP_LIMIT   identical consecutive raw bits that trigger a health failure (>=2)
//   SYNC_STAGES synchroniser depth for bit_done and bit_in (>=2)
//
// Ports
//   clk          system clock
//   rst_b        asynchronous active-low reset
//   start        pulse, begin generating (IDLE only; stop wins if both are set)
//   stop         pulse, abort collection / finish after the current delivery
//   clear        pulse, leave FAIL and return to IDLE
//   bit_in       core rnd_bit, asynchronous to clk
//   bit_done     core done level, a rising edge marks a new bit
//   core_rst_b   active-low reset to the core (released in COLLECT/DELIVER)
//   word_out     assembled word, stable while word_valid is high
//   word_valid   word_out holds an undelivered word
//   word_ready   consumer takes word_out this cycle
//   busy         FSM is not in IDLE
//   health_fail  sticky repetition-test failure flag
//
// Configuration
//   PADLOCK_VN_EN  when defined, von Neumann debiasing is applied to raw bit
//                  pairs (01 -> 0, 10 -> 1, 00/11 dropped). When undefined,
//                  every accepted raw bit is appended directly.

module padlock_word_ctrl #(
  parameter int WIDTH       = 32,
  parameter int REP_LIMIT   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             bit_in,
  input  logic             bit_done,
  output logic             core_rst_b,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             health_fail
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DELIVER = 2'd2;
  localparam logic [1:0] ST_FAIL    = 2'd3;

  localparam int CNT_W = $clog2(WIDTH);
  localparam int REP_W = $clog2(REP_LIMIT + 1);

  logic [1:0]             state;
  logic [SYNC_STAGES-1:0] done_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   done_prev;
  logic [CNT_W-1:0]       bit_cnt;
  logic [REP_W-1:0]       rep_cnt;
  logic                   last_bit;
  logic                   stop_pend;
  // Only the low WIDTH-1 bits are kept; the newest bit completes the word.
  logic [WIDTH-2:0]       shreg;
`ifdef PADLOCK_VN_EN
  logic                   pair_have;
  logic                   pair_bit;
`endif

  logic             done_s;
  logic             raw_bit;
  logic             raw_ok;
  logic [REP_W-1:0] rep_next;
  logic             rep_hit;
  logic             app_valid;
  logic             app_bit;
  logic [WIDTH-1:0] word_next;
  logic             word_done;

  // Both synchronisers have the same depth so bit_in lines up with its done edge.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      done_sync <= '0;
      data_sync <= '0;
    end else begin
      done_sync <= {done_sync[SYNC_STAGES-2:0], bit_done};
      data_sync <= {data_sync[SYNC_STAGES-2:0], bit_in};
    end
  end

  assign done_s  = done_sync[SYNC_STAGES-1];
  assign raw_bit = data_sync[SYNC_STAGES-1];

  assign core_rst_b = (state == ST_COLLECT) || (state == ST_DELIVER);
  assign busy       = (state != ST_IDLE);

  // Health test and bit appending. rep_cnt == 0 means no previous raw bit
  // since the last start, so the first bit always begins a fresh run.
  always_comb begin
    raw_ok = done_s && !done_prev && core_rst_b;

    rep_next = rep_cnt;
    if (rep_cnt == '0 || raw_bit != last_bit)
      rep_next = REP_W'(1);
    else if (rep_cnt != REP_W'(REP_LIMIT))
      rep_next = rep_cnt + 1'b1;
    rep_hit = raw_ok && (rep_next == REP_W'(REP_LIMIT));

`ifdef PADLOCK_VN_EN
    app_valid = raw_ok && (state == ST_COLLECT) && pair_have && (pair_bit != raw_bit);
    app_bit   = pair_bit;
`else
    app_valid = raw_ok && (state == ST_COLLECT);
    app_bit   = raw_bit;
`endif

    word_next = {shreg, app_bit};
    word_done = app_valid && (bit_cnt == CNT_W'(WIDTH - 1));
  end

  // Main sequencer. A health hit overrides completion, handshake and stop.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state       <= ST_IDLE;
      done_prev   <= 1'b0;
      bit_cnt     <= '0;
      rep_cnt     <= '0;
      last_bit    <= 1'b0;
      stop_pend   <= 1'b0;
      shreg       <= '0;
      word_out    <= '0;
      word_valid  <= 1'b0;
      health_fail <= 1'b0;
`ifdef PADLOCK_VN_EN
      pair_have   <= 1'b0;
      pair_bit    <= 1'b0;
`endif
    end else begin
      done_prev <= done_s;
      if (raw_ok) begin
        rep_cnt  <= rep_next;
        last_bit <= raw_bit;
      end

      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            state     <= ST_COLLECT;
            bit_cnt   <= '0;
            rep_cnt   <= '0;
            done_prev <= 1'b0;
            shreg     <= '0;
            stop_pend <= 1'b0;
`ifdef PADLOCK_VN_EN
            pair_have <= 1'b0;
`endif
          end
        end

        ST_COLLECT: begin
          if (rep_hit) begin
            state       <= ST_FAIL;
            health_fail <= 1'b1;
          end else if (stop) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
          end else begin
`ifdef PADLOCK_VN_EN
            if (raw_ok) begin
              pair_have <= !pair_have;
              if (!pair_have)
                pair_bit <= raw_bit;
            end
`endif
            if (app_valid) begin
              shreg   <= word_next[WIDTH-2:0];
              bit_cnt <= bit_cnt + 1'b1;
              if (word_done) begin
                state      <= ST_DELIVER;
                word_out   <= word_next;
                word_valid <= 1'b1;
                stop_pend  <= 1'b0;
              end
            end
          end
        end

        ST_DELIVER: begin
          if (rep_hit) begin
            state       <= ST_FAIL;
            health_fail <= 1'b1;
            word_valid  <= 1'b0;
            stop_pend   <= 1'b0;
          end else begin
            if (stop)
              stop_pend <= 1'b1;
            if (word_ready) begin
              word_valid <= 1'b0;
              bit_cnt    <= '0;
              stop_pend  <= 1'b0;
              state      <= (stop_pend || stop) ? ST_IDLE : ST_COLLECT;
`ifdef PADLOCK_VN_EN
              pair_have  <= 1'b0;
`endif
            end
          end
        end

        default: begin
          word_valid  <= 1'b0;
          health_fail <= 1'b1;
          if (clear) begin
            state       <= ST_IDLE;
            health_fail <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_padlock_word_ctrl.sv
// tb_padlock_word_ctrl
//   Directed testbench for padlock_word_ctrl. With PADLOCK_VN_EN undefined it
//   uses WIDTH=8 and REP_LIMIT=4. With PADLOCK_VN_EN defined it uses WIDTH=4
//   and REP_LIMIT=8, so the debiasing sequence does not trip the health test.

module tb_padlock_word_ctrl;

`ifdef PADLOCK_VN_EN
  localparam int W  = 4;
  localparam int RL = 8;
`else
  localparam int W  = 8;
  localparam int RL = 4;
`endif

  logic         clk = 1'b0;
  logic         rst_b = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         clear = 1'b0;
  logic         bit_in = 1'b0;
  logic         bit_done = 1'b0;
  logic         word_ready = 1'b0;
  logic         core_rst_b;
  logic [W-1:0] word_out;
  logic         word_valid;
  logic         busy;
  logic         health_fail;

  int n_cmp = 0;
  int n_bad = 0;

  padlock_word_ctrl #(.WIDTH(W), .REP_LIMIT(RL), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .stop(stop), .clear(clear),
    .bit_in(bit_in), .bit_done(bit_done), .core_rst_b(core_rst_b),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .busy(busy), .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_stop;
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  // Raise done with the bit, hold it, then drop it long enough to rearm the edge.
  task automatic send_bit(input logic b, input int hold);
    bit_in = b;
    bit_done = 1'b1;
    repeat (hold) tick();
    bit_done = 1'b0;
    repeat (4) tick();
  endtask

  task automatic handshake;
    word_ready = 1'b1; tick(); word_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) tick();
    rst_b = 1'b1;
    tick();
    n_cmp++; if (core_rst_b !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_core_rst_b: got %b want 0", core_rst_b); end
    n_cmp++; if (word_out !== '0) begin n_bad++; $display("[TB] FAIL reset_word_out: got %h want 0", word_out); end
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_word_valid: got %b want 0", word_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (health_fail !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_health: got %b want 0", health_fail); end
    pulse_start();
    send_bit(1'b1, 3);
    send_bit(1'b0, 3);
    send_bit(1'b1, 3);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL collect_busy: got %b want 1", busy); end
    n_cmp++; if (core_rst_b !== 1'b1) begin n_bad++; $display("[TB] FAIL collect_core_rst_b: got %b want 1", core_rst_b); end
    #2 rst_b = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL async_reset_busy: got %b want 0", busy); end
    n_cmp++; if (core_rst_b !== 1'b0) begin n_bad++; $display("[TB] FAIL async_reset_core_rst_b: got %b want 0", core_rst_b); end
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL async_reset_valid: got %b want 0", word_valid); end
    tick();
    rst_b = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL post_reset_busy: got %b want 0", busy); end
  endtask

`ifdef PADLOCK_VN_EN
  task automatic test_vn;
    logic [11:0] raw;
    raw = 12'b0110_1110_0001;
    pulse_start();
    for (int i = 11; i >= 2; i--) send_bit(raw[i], 3);
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL vn_early_valid: got %b want 0", word_valid); end
    send_bit(raw[1], 3);
    send_bit(raw[0], 3);
    n_cmp++; if (word_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL vn_valid: got %b want 1", word_valid); end
    n_cmp++; if (word_out !== 4'b0110) begin n_bad++; $display("[TB] FAIL vn_word: got %b want 0110", word_out); end
    n_cmp++; if (health_fail !== 1'b0) begin n_bad++; $display("[TB] FAIL vn_health: got %b want 0", health_fail); end
    handshake();
    pulse_stop();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL vn_stop_busy: got %b want 0", busy); end
  endtask
`else
  task automatic test_back_to_back;
    logic [7:0] w2;
    w2 = 8'h5A;
    pulse_start();
    for (int i = 0; i < 8; i++) send_bit(logic'(((i % 2) == 0)), 3);
    n_cmp++; if (word_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL word1_valid: got %b want 1", word_valid); end
    n_cmp++; if (word_out !== 8'hAA) begin n_bad++; $display("[TB] FAIL word1_value: got %h want aa", word_out); end
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++; if (word_out !== 8'hAA || word_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL word1_hold cycle %0d: got %h/%b want aa/1", c, word_out, word_valid); end
    end
    send_bit(1'b1, 3);
    send_bit(1'b0, 3);
    n_cmp++; if (word_out !== 8'hAA) begin n_bad++; $display("[TB] FAIL deliver_discard: got %h want aa", word_out); end
    handshake();
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL word1_accept_valid: got %b want 0", word_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL word1_accept_busy: got %b want 1", busy); end
    for (int i = 7; i >= 0; i--) send_bit(w2[i], 3);
    n_cmp++; if (word_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL word2_valid: got %b want 1", word_valid); end
    n_cmp++; if (word_out !== 8'h5A) begin n_bad++; $display("[TB] FAIL word2_value: got %h want 5a", word_out); end
    handshake();
    pulse_stop();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL collect_stop_busy: got %b want 0", busy); end
  endtask

  task automatic test_start_stop;
    logic [7:0] w;
    w = 8'hCC;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL start_stop_busy: got %b want 0", busy); end
    n_cmp++; if (core_rst_b !== 1'b0) begin n_bad++; $display("[TB] FAIL start_stop_core: got %b want 0", core_rst_b); end
    pulse_start();
    for (int i = 7; i >= 0; i--) send_bit(w[i], 3);
    pulse_stop();
    repeat (3) tick();
    n_cmp++; if (word_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL stop_deliver_valid: got %b want 1", word_valid); end
    n_cmp++; if (word_out !== 8'hCC) begin n_bad++; $display("[TB] FAIL stop_deliver_word: got %h want cc", word_out); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL stop_deliver_busy: got %b want 1", busy); end
    handshake();
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL stop_deliver_done_valid: got %b want 0", word_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL stop_deliver_idle: got %b want 0", busy); end
  endtask

  task automatic test_health;
    pulse_start();
    for (int i = 0; i < 3; i++) send_bit(1'b1, 3);
    n_cmp++; if (health_fail !== 1'b0) begin n_bad++; $display("[TB] FAIL health_early: got %b want 0", health_fail); end
    send_bit(1'b1, 3);
    n_cmp++; if (health_fail !== 1'b1) begin n_bad++; $display("[TB] FAIL health_trip: got %b want 1", health_fail); end
    n_cmp++; if (core_rst_b !== 1'b0) begin n_bad++; $display("[TB] FAIL health_core: got %b want 0", core_rst_b); end
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL health_valid: got %b want 0", word_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL health_busy: got %b want 1", busy); end
    pulse_start();
    pulse_stop();
    tick();
    n_cmp++; if (health_fail !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("[TB] FAIL health_ignore: got %b/%b want 1/1", health_fail, busy); end
    clear = 1'b1; tick(); clear = 1'b0;
    n_cmp++; if (health_fail !== 1'b0) begin n_bad++; $display("[TB] FAIL health_clear: got %b want 0", health_fail); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL health_clear_busy: got %b want 0", busy); end
  endtask

  task automatic test_latency;
    pulse_start();
    send_bit(1'b1, 20);
    for (int i = 0; i < 6; i++) send_bit(logic'(((i % 2) == 1)), 3);
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL long_done_one_bit: got %b want 0", word_valid); end
    bit_in = 1'b0;
    bit_done = 1'b1;
    tick();
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL latency_edge1: got %b want 0", word_valid); end
    tick();
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL latency_edge2: got %b want 0", word_valid); end
    tick();
    n_cmp++; if (word_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL latency_edge3: got %b want 1", word_valid); end
    n_cmp++; if (word_out !== 8'hAA) begin n_bad++; $display("[TB] FAIL latency_word: got %h want aa", word_out); end
    bit_done = 1'b0;
    repeat (4) tick();
    handshake();
    pulse_stop();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL latency_stop_busy: got %b want 0", busy); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef PADLOCK_VN_EN
    test_vn();
`else
    test_back_to_back();
    test_start_stop();
    test_health();
    test_latency();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
